// File: rtl/ct_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM wrapper.
// Holds the FSM state encoding and the geometry check used at elaboration.
package ct_spsram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // The write mask must split the data word into equal whole groups.
  function automatic bit widthsOk(input int unsigned dataW, input int unsigned weW);
    return (weW != 0) && ((dataW % weW) == 0);
  endfunction

endpackage

// File: rtl/ct_spsram_param_init_if.sv
// Access port bundle of the SRAM wrapper: active-low SRAM controls plus read/init status.
interface ct_spsram_param_init_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 104,
  parameter int WE_WIDTH   = 104
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Q_VLD;
  logic                  INIT_BUSY;

  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q, Q_VLD, INIT_BUSY
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q, Q_VLD, INIT_BUSY
  );
endinterface

// File: rtl/ct_spsram_core.sv
// Behavioural storage array with SRAM-macro semantics and no reset.
// Kept separate so a foundry or FPGA macro can replace it unchanged.
module ct_spsram_core #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 104,
  parameter int WE_WIDTH   = 104
) (
  input  logic                  CLK,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);
  localparam int G     = DATA_WIDTH / WE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Q only moves on a read; a write leaves the last read data in place.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (GWEN) begin
        Q <= r_mem[A];
      end else begin
        for (int i = 0; i < WE_WIDTH; i++) begin
          if (!WEN[i]) begin
            r_mem[A][i*G +: G] <= D[i*G +: G];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM wrapper: post-reset init sweep, optional output flop,
// and a one-cycle Q_VLD pulse aligned with each read result.
module ct_spsram_param_init
  import ct_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 104,
  parameter int                    WE_WIDTH   = 104,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                   CLK,
  input  logic                   cpurst_b,
  ct_spsram_param_init_if.slave  bus
);
  localparam int                    DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  if (!widthsOk(DATA_WIDTH, WE_WIDTH)) begin : g_badWidths
    $error("ct_spsram_param_init: DATA_WIDTH must be a multiple of WE_WIDTH");
  end

  state_e                r_state;
  state_e                w_nextState;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_busy;
  logic                  w_rd;
  logic                  r_rdVld;
  logic [ADDR_WIDTH-1:0] w_coreA;
  logic                  w_coreCen;
  logic                  w_coreGwen;
  logic [WE_WIDTH-1:0]   w_coreWen;
  logic [DATA_WIDTH-1:0] w_coreD;
  logic [DATA_WIDTH-1:0] w_coreQ;

  assign w_busy        = (r_state == INIT);
  assign w_rd          = !w_busy && !bus.CEN && bus.GWEN;
  assign bus.INIT_BUSY = w_busy;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= INIT_EN ? INIT : IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // While sweeping, the counter and INIT_VAL own the array; the external port is shut out.
  always_comb begin
    w_nextState = r_state;
    w_coreA     = bus.A;
    w_coreCen   = bus.CEN;
    w_coreGwen  = bus.GWEN;
    w_coreWen   = bus.WEN;
    w_coreD     = bus.D;
    if (r_state == INIT) begin
      w_coreA    = r_cnt;
      w_coreCen  = 1'b0;
      w_coreGwen = 1'b0;
      w_coreWen  = '0;
      w_coreD    = INIT_VAL;
      if (r_cnt == LAST) begin
        w_nextState = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cnt   <= '0;
      r_rdVld <= 1'b0;
    end else begin
      r_rdVld <= w_rd;
      if (w_busy) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  ct_spsram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH)
  ) u_core (
    .CLK  (CLK),
    .A    (w_coreA),
    .CEN  (w_coreCen),
    .GWEN (w_coreGwen),
    .WEN  (w_coreWen),
    .D    (w_coreD),
    .Q    (w_coreQ)
  );

  if (OUT_REG) begin : g_outReg
    logic [DATA_WIDTH-1:0] r_qPipe;
    logic                  r_vldPipe;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        r_qPipe   <= '0;
        r_vldPipe <= 1'b0;
      end else begin
        r_vldPipe <= r_rdVld;
        if (r_rdVld) begin
          r_qPipe <= w_coreQ;
        end
      end
    end

    assign bus.Q     = r_qPipe;
    assign bus.Q_VLD = r_vldPipe;
  end else begin : g_noOutReg
    // The macro output has no reset, so Q reads as zero until the first read lands.
    logic r_hasRead;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        r_hasRead <= 1'b0;
      end else if (w_rd) begin
        r_hasRead <= 1'b1;
      end
    end

    assign bus.Q     = r_hasRead ? w_coreQ : '0;
    assign bus.Q_VLD = r_rdVld;
  end

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Randomised self-checking bench: two wrappers (WE=104/no out flop, WE=13/out flop)
// compared every cycle against a per-entry array model with read-latency scheduling.
module tb_ct_spsram_param_init;
  localparam int AW    = 7;
  localparam int DW    = 104;
  localparam int DEPTH = 128;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic CLK      = 1'b0;
  logic cpurst_b = 1'b1;

  always #5 CLK = ~CLK;

  ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(104)) bus0 ();
  ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(13))  bus1 ();

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(104),
    .OUT_REG(1'b0), .INIT_EN(1'b1), .INIT_VAL(INIT_VAL)
  ) dut0 (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .bus      (bus0)
  );

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(13),
    .OUT_REG(1'b1), .INIT_EN(1'b1), .INIT_VAL(INIT_VAL)
  ) dut1 (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .bus      (bus1)
  );

  logic [AW-1:0] sA    [2];
  logic          sCen  [2];
  logic          sGwen [2];
  logic [DW-1:0] sWen  [2];
  logic [DW-1:0] sD    [2];

  assign bus0.A    = sA[0];
  assign bus0.CEN  = sCen[0];
  assign bus0.GWEN = sGwen[0];
  assign bus0.WEN  = sWen[0];
  assign bus0.D    = sD[0];
  assign bus1.A    = sA[1];
  assign bus1.CEN  = sCen[1];
  assign bus1.GWEN = sGwen[1];
  assign bus1.WEN  = sWen[1][12:0];
  assign bus1.D    = sD[1];

  logic [DW-1:0] mem       [2][DEPTH];
  logic          schedVld  [2][4];
  logic [DW-1:0] schedData [2][4];
  logic [DW-1:0] expQ      [2];
  logic          expVld    [2];
  int            busyLeft;
  bit            inReset;
  int            edgeN;
  int            errors;
  int            checks;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s edge=%0d got=%h expected=%h", tag, edgeN, got, exp);
    end
  endtask

  task automatic checkDut(input int d);
    logic [DW-1:0] q;
    logic          vld;
    logic          busy;
    q    = (d == 0) ? bus0.Q : bus1.Q;
    vld  = (d == 0) ? bus0.Q_VLD : bus1.Q_VLD;
    busy = (d == 0) ? bus0.INIT_BUSY : bus1.INIT_BUSY;
    checkOutput($sformatf("dut%0d.Q", d), q, expQ[d]);
    checkOutput($sformatf("dut%0d.Q_VLD", d), DW'(vld), DW'(expVld[d]));
    checkOutput($sformatf("dut%0d.INIT_BUSY", d), DW'(busy), DW'(inReset || busyLeft > 0));
  endtask

  task automatic applyStimulus(input int d, input logic cen, input logic gwen, input logic [AW-1:0] a,
                               input logic [DW-1:0] wen, input logic [DW-1:0] data);
    sCen[d]  = cen;
    sGwen[d] = gwen;
    sA[d]    = a;
    sWen[d]  = wen;
    sD[d]    = data;
  endtask

  function automatic logic [DW-1:0] rand104();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic randomStim(input int d);
    logic [DW-1:0] wen;
    logic [AW-1:0] a;
    int            mode;
    mode = $urandom_range(0, 3);
    wen  = (mode == 0) ? '0 : (mode == 1) ? '1 : rand104();
    a    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1));
    applyStimulus(d, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, wen, rand104());
  endtask

  task automatic idleStim(input int d);
    applyStimulus(d, 1'b1, 1'b1, '0, '1, '0);
  endtask

  // Reference behaviour of one port at one rising edge, from the access rules alone.
  task automatic modelEdge(input int d);
    int lat;
    int grp;
    int slot;
    int due;
    lat  = (d == 0) ? 1 : 2;
    grp  = (d == 0) ? 1 : 8;
    slot = edgeN % 4;
    if (!inReset) begin
      if (busyLeft == 0 && !sCen[d]) begin
        if (sGwen[d]) begin
          due = (edgeN + lat - 1) % 4;
          schedVld[d][due]  = 1'b1;
          schedData[d][due] = mem[d][sA[d]];
        end else begin
          for (int b = 0; b < DW; b++) begin
            if (!sWen[d][b / grp]) mem[d][sA[d]][b] = sD[d][b];
          end
        end
      end
      if (schedVld[d][slot]) begin
        expVld[d]         = 1'b1;
        expQ[d]           = schedData[d][slot];
        schedVld[d][slot] = 1'b0;
      end else begin
        expVld[d] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    edgeN++;
    modelEdge(0);
    modelEdge(1);
    if (!inReset && busyLeft > 0) busyLeft--;
    #1;
    checkDut(0);
    checkDut(1);
  endtask

  task automatic assertReset();
    cpurst_b = 1'b0;
    inReset  = 1'b1;
    busyLeft = DEPTH;
    for (int d = 0; d < 2; d++) begin
      expQ[d]   = '0;
      expVld[d] = 1'b0;
      for (int s = 0; s < 4; s++) schedVld[d][s] = 1'b0;
    end
    #1;
    checkDut(0);
    checkDut(1);
  endtask

  task automatic releaseReset();
    cpurst_b = 1'b1;
    inReset  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < DEPTH; a++) mem[d][a] = INIT_VAL;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edgeN  = 0;
    idleStim(0);
    idleStim(1);
    #2;
    assertReset();
    repeat (3) cycle();
    releaseReset();

    // Sweep window: traffic must be ignored, including a full write to entry 4.
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 10) applyStimulus(0, 1'b0, 1'b0, AW'(4), '0, '1);
      else         randomStim(0);
      randomStim(1);
      cycle();
    end
    idleStim(0);
    idleStim(1);
    cycle();

    // Post-init reads, including entry 4 and the top entry; dut1 streams back-to-back.
    applyStimulus(0, 1'b0, 1'b1, AW'(4), '1, '0);
    applyStimulus(1, 1'b0, 1'b1, AW'(4), '1, '0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1'b0, 1'b1, (k == 0) ? AW'(0) : (k == 1) ? AW'(5) : AW'(127), '1, '0);
      applyStimulus(1, 1'b0, 1'b1, AW'(k + 1), '1, '0);
      cycle();
    end
    idleStim(0);
    idleStim(1);
    repeat (3) cycle();

    // Partial-mask writes: lower half on dut0, only group 0 on the 13-group dut1.
    applyStimulus(0, 1'b0, 1'b0, AW'(3), {{52{1'b1}}, {52{1'b0}}}, {13{8'hAA}});
    applyStimulus(1, 1'b0, 1'b0, AW'(9), DW'(13'h1FFE), '1);
    cycle();
    applyStimulus(0, 1'b0, 1'b1, AW'(3), '1, '0);
    applyStimulus(1, 1'b0, 1'b1, AW'(9), '1, '0);
    cycle();
    idleStim(0);
    idleStim(1);
    repeat (3) cycle();

    // Read followed by a write to the same entry, then read it back.
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b1, AW'(3), '1, '0);
    cycle();
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b0, AW'(3), '0, rand104());
    cycle();
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b1, AW'(3), '1, '0);
    cycle();
    idleStim(0);
    idleStim(1);
    repeat (3) cycle();

    for (int k = 0; k < 600; k++) begin
      randomStim(0);
      randomStim(1);
      cycle();
    end

    // Reset lands with a read in flight on the output-flop instance.
    applyStimulus(0, 1'b0, 1'b1, AW'(3), '1, '0);
    applyStimulus(1, 1'b0, 1'b1, AW'(3), '1, '0);
    cycle();
    idleStim(0);
    idleStim(1);
    assertReset();
    repeat (2) cycle();
    releaseReset();

    // Interrupt the sweep at entry 50 and confirm it starts over.
    for (int k = 0; k < 50; k++) begin
      randomStim(0);
      randomStim(1);
      cycle();
    end
    assertReset();
    repeat (2) cycle();
    releaseReset();
    for (int k = 0; k < DEPTH; k++) begin
      randomStim(0);
      randomStim(1);
      cycle();
    end

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(0, 1'b0, 1'b1, AW'(a), '1, '0);
      applyStimulus(1, 1'b0, 1'b1, AW'(a), '1, '0);
      cycle();
    end
    idleStim(0);
    idleStim(1);
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
